// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle instruction sequencer for the VeriRISC core.
//   Latency: strobes are registered, one cycle behind the state shown on `state`.
//   Backpressure: stall=1 freezes state, wait counter, strobes and retire counter.
// Ports:
//   clk, rst_            clock and async active-low reset
//   opcode, zero         IR opcode and accumulator-zero flag, decoded combinationally
//   stall, run           global freeze; resume from HALTED
//   mem_rd..mem_wr       registered control strobes
//   state                present state (direct view of the state register)
//   instr_count          retired-instruction count, wraps at 2^CNT_W
module ctrl_seq #(
  parameter int MEM_WAIT = 0,   // extra wait cycles after each fetch, 0..15
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             stall,
  input  logic             run,
  output logic             mem_rd,
  output logic             load_ir,
  output logic             halt,
  output logic             inc_pc,
  output logic             load_ac,
  output logic             load_pc,
  output logic             mem_wr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    WAIT       = 4'd8,
    HALTED     = 4'd9
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam bit         HAS_WAIT = (MEM_WAIT > 0);
  // WAIT is held for MEM_WAIT cycles: counter starts at MEM_WAIT-1 and exits at 0.
  localparam logic [3:0] WLOAD    = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

  // Strobe vector order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}
  state_t     cur, nxt;
  logic [3:0] wcnt, wcnt_nxt;
  logic       ret, ret_nxt;     // 0: WAIT returns to INST_LOAD, 1: to ALU_OP
  logic [6:0] vec, vec_q;
  logic       retire;

  logic       aluop, is_jmp, is_sto, is_hlt, skz_t;
  logic [6:0] fetch_i_vec, fetch_o_vec;

  always_comb begin
    aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
             (opcode == OP_XOR) || (opcode == OP_LDA);
    is_jmp = (opcode == OP_JMP);
    is_sto = (opcode == OP_STO);
    is_hlt = (opcode == OP_HLT);
    skz_t  = (opcode == OP_SKZ) && zero;
    fetch_i_vec = 7'b1100000;
    fetch_o_vec = {aluop, 1'b0, 1'b0, skz_t, aluop, is_jmp, 1'b0};
  end

  always_comb begin
    nxt      = cur;
    wcnt_nxt = wcnt;
    ret_nxt  = ret;
    vec      = '0;
    retire   = 1'b0;
    case (cur)
      INST_ADDR: begin
        vec = 7'b1000000;
        nxt = INST_FETCH;
      end
      INST_FETCH: begin
        vec = fetch_i_vec;
        if (HAS_WAIT) begin
          nxt      = WAIT;
          wcnt_nxt = WLOAD;
          ret_nxt  = 1'b0;
        end else begin
          nxt = INST_LOAD;
        end
      end
      INST_LOAD: begin
        vec = fetch_i_vec;
        nxt = IDLE;
      end
      IDLE: begin
        vec = {2'b00, is_hlt, 1'b1, 3'b000};
        nxt = is_hlt ? HALTED : OP_ADDR;
      end
      OP_ADDR: begin
        vec = {aluop, 6'b000000};
        nxt = OP_FETCH;
      end
      OP_FETCH: begin
        vec = fetch_o_vec;
        if (HAS_WAIT) begin
          nxt      = WAIT;
          wcnt_nxt = WLOAD;
          ret_nxt  = 1'b1;
        end else begin
          nxt = ALU_OP;
        end
      end
      ALU_OP: begin
        vec = {aluop, 1'b0, 1'b0, is_jmp, aluop, is_jmp, is_sto};
        nxt = STORE;
      end
      STORE: begin
        nxt    = INST_ADDR;
        retire = 1'b1;
      end
      WAIT: begin
        // Keep presenting the vector of the fetch being stretched.
        vec = ret ? fetch_o_vec : fetch_i_vec;
        if (wcnt == 4'd0) begin
          nxt = ret ? ALU_OP : INST_LOAD;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      HALTED: begin
        vec = 7'b0010000;
        if (run) nxt = INST_ADDR;
      end
      default: begin
        nxt = INST_ADDR;
        vec = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cur         <= INST_ADDR;
      wcnt        <= 4'd0;
      ret         <= 1'b0;
      vec_q       <= '0;
      instr_count <= '0;
    end else if (!stall) begin
      cur   <= nxt;
      wcnt  <= wcnt_nxt;
      ret   <= ret_nxt;
      vec_q <= vec;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr} = vec_q;
  assign state = cur;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: drives three ctrl_seq instances (MEM_WAIT 0/3/4, CNT_W 2/16/4)
// from shared stimulus and compares each against a position-in-instruction
// reference model every cycle.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_;
  logic [2:0] opcode;
  logic       zero, stall, run;

  logic [3:0]  st_o  [3];
  logic [6:0]  vec_o [3];
  logic [15:0] cnt_o [3];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MW = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
    localparam int CW = (g == 0) ? 2 : ((g == 1) ? 16 : 4);
    logic [CW-1:0] cnt;
    ctrl_seq #(.MEM_WAIT(MW), .CNT_W(CW)) u_dut (
      .clk         (clk),
      .rst_        (rst_),
      .opcode      (opcode),
      .zero        (zero),
      .stall       (stall),
      .run         (run),
      .mem_rd      (vec_o[g][6]),
      .load_ir     (vec_o[g][5]),
      .halt        (vec_o[g][4]),
      .inc_pc      (vec_o[g][3]),
      .load_ac     (vec_o[g][2]),
      .load_pc     (vec_o[g][1]),
      .mem_wr      (vec_o[g][0]),
      .state       (st_o[g]),
      .instr_count (cnt)
    );
    assign cnt_o[g] = 16'(cnt);
  end

  // Reference model: position within an instruction of length 8+2W.
  int         mw [3] = '{0, 3, 4};
  int         cm [3] = '{3, 65535, 15};
  int         m_pos  [3];
  bit         m_halt [3];
  logic [6:0] m_vec  [3];
  int         m_cnt  [3];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Phase name at a position: 0..7 as the base phases, 8 = wait, W wait slots after each fetch.
  function automatic int phase_of(input int w, input int pos);
    if (pos == 0)          return 0;
    if (pos == 1)          return 1;
    if (pos < 2 + w)       return 8;
    if (pos == 2 + w)      return 2;
    if (pos == 3 + w)      return 3;
    if (pos == 4 + w)      return 4;
    if (pos == 5 + w)      return 5;
    if (pos < 6 + 2 * w)   return 8;
    if (pos == 6 + 2 * w)  return 6;
    return 7;
  endfunction

  function automatic logic [6:0] vec_of(input int w, input int pos);
    int   p;
    logic alu, jmp, sto, skz;
    p   = phase_of(w, pos);
    if (p == 8) p = (pos < 2 + w) ? 1 : 5;
    alu = (opcode >= 3'd2) && (opcode <= 3'd5);
    jmp = (opcode == 3'd7);
    sto = (opcode == 3'd6);
    skz = (opcode == 3'd1) && zero;
    case (p)
      0:       return 7'b1000000;
      1, 2:    return 7'b1100000;
      3:       return {2'b00, (opcode == 3'd0), 1'b1, 3'b000};
      4:       return {alu, 6'b0};
      5:       return {alu, 2'b00, skz, alu, jmp, 1'b0};
      6:       return {alu, 2'b00, jmp, alu, jmp, sto};
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_pos[d] = 0; m_halt[d] = 0; m_vec[d] = '0; m_cnt[d] = 0;
    end
  endtask

  // Advance the model across the coming rising edge using the present inputs.
  task automatic model_step();
    int w;
    for (int d = 0; d < 3; d++) begin
      w = mw[d];
      if (!rst_) begin
        m_pos[d] = 0; m_halt[d] = 0; m_vec[d] = '0; m_cnt[d] = 0;
      end else if (!stall) begin
        if (m_halt[d]) begin
          m_vec[d] = 7'b0010000;
          if (run) begin
            m_halt[d] = 0;
            m_pos[d]  = 0;
          end
        end else begin
          m_vec[d] = vec_of(w, m_pos[d]);
          if (m_pos[d] == 3 + w && opcode == 3'd0) begin
            m_halt[d] = 1;
          end else if (m_pos[d] == 7 + 2 * w) begin
            m_pos[d] = 0;
            m_cnt[d] = (m_cnt[d] + 1) & cm[d];
          end else begin
            m_pos[d]++;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      chk_eq($sformatf("state%0d", d), 32'(st_o[d]),
             m_halt[d] ? 32'd9 : 32'(phase_of(mw[d], m_pos[d])));
      chk_eq($sformatf("strobes%0d", d), 32'(vec_o[d]), 32'(m_vec[d]));
      chk_eq($sformatf("count%0d", d), 32'(cnt_o[d]), 32'(m_cnt[d]));
    end
  endtask

  // Called just after a falling edge: check, drive, predict, wait one clock.
  task automatic cycle(input logic [2:0] op, input logic z, input logic st, input logic rn);
    check_all();
    opcode = op; zero = z; stall = st; run = rn;
    model_step();
    @(negedge clk);
  endtask

  task automatic run_rand(input int n);
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
      cycle(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0));
    end
  endtask

  initial begin
    rst_ = 1'b0; opcode = 3'd2; zero = 1'b0; stall = 1'b0; run = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all();
    end
    rst_ = 1'b1;

    // Plain instruction stream, then each opcode class.
    for (int i = 0; i < 30; i++) cycle(3'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      logic [2:0] op;
      logic       z;
      op = (k == 0) ? 3'd1 : (k == 1) ? 3'd1 : 3'(k + 1);
      z  = (k == 0);
      for (int i = 0; i < 30; i++) cycle(op, z, 1'b0, 1'b0);
    end

    // Halt, sit idle with run low, then resume.
    for (int i = 0; i < 40; i++) cycle(3'd0, 1'b0, 1'b0, 1'b0);
    cycle(3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(3'd5, 1'b0, 1'b0, 1'b0);

    // Freeze the MEM_WAIT=4 instance in the middle of its fetch wait.
    begin
      int i;
      i = 0;
      while (i < 40 && !(m_pos[2] == 3 && !m_halt[2])) begin
        cycle(3'd5, 1'b0, 1'b0, 1'b0);
        i++;
      end
      chk_eq("reach_wait", 32'(m_pos[2] == 3), 32'd1);
    end
    for (int i = 0; i < 5; i++) cycle(3'd5, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(3'd5, 1'b0, 1'b0, 1'b0);

    run_rand(600);

    // Asynchronous reset while the MEM_WAIT=3 instance sits in OP_FETCH.
    begin
      int i;
      i = 0;
      while (i < 60 && !(m_pos[1] == 8 && !m_halt[1])) begin
        cycle(3'd2, 1'b0, 1'b0, 1'b1);
        i++;
      end
      chk_eq("reach_opfetch", 32'(m_pos[1] == 8), 32'd1);
    end
    check_all();
    #2 rst_ = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_ = 1'b1;

    run_rand(400);
    check_all();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised multi-cycle instruction sequencer for the VeriRISC CPU core. It drives the memory, instruction-register, accumulator and program-counter enables for the eight-opcode ISA, which keeps its eight base phases. New over the fixed 8-phase controller: configurable memory wait states, a sticky HALTED state with a run-resume input, a global stall input, and a retired-instruction counter.

## Interface
Parameters:
- MEM_WAIT, 0: extra wait cycles inserted after each fetch phase; legal range 0..15.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_  in  1  asynchronous, active-low reset.
- opcode  in  3  current IR opcode: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  in  1  accumulator-zero flag.
- stall  in  1  freeze sequencer while high.
- run  in  1  resume from HALTED; ignored in any other state.
- mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr  out  1 each  registered control strobes.
- state  out  4  present state: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7, WAIT=8, HALTED=9.
- instr_count  out  CNT_W  retired-instruction count.

## Operation
- Decode terms: ALUOP = opcode in {ADD, AND, XOR, LDA}. JMP = opcode==JMP. STO = opcode==STO. SKZ_T = (opcode==SKZ) && zero.
- Transitions, with no stall:
  - INST_ADDR -> INST_FETCH.
  - INST_FETCH -> WAIT(ret=INST_LOAD) if MEM_WAIT>0, else INST_LOAD.
  - INST_LOAD -> IDLE.
  - IDLE -> HALTED if opcode==HLT, else OP_ADDR.
  - OP_ADDR -> OP_FETCH.
  - OP_FETCH -> WAIT(ret=ALU_OP) if MEM_WAIT>0, else ALU_OP.
  - ALU_OP -> STORE.
  - STORE -> INST_ADDR.
  - WAIT -> ret when wcnt==0.
  - HALTED -> INST_ADDR when run==1.
  - Illegal codes 10..15 -> INST_ADDR with an all-zero vector.
- WAIT: wcnt loads MEM_WAIT-1 on entry and decrements each cycle; a 1-bit ret register records the return phase.
- Control vector per state, listing the strobes that are 1 (all others 0):
  - INST_ADDR: mem_rd.
  - INST_FETCH, INST_LOAD: mem_rd, load_ir.
  - IDLE: inc_pc, and halt=(opcode==HLT).
  - OP_ADDR: mem_rd=ALUOP.
  - OP_FETCH: mem_rd=ALUOP, inc_pc=SKZ_T, load_ac=ALUOP, load_pc=JMP.
  - ALU_OP: mem_rd=ALUOP, inc_pc=JMP, load_ac=ALUOP, load_pc=JMP, mem_wr=STO.
  - STORE: none.
  - WAIT: repeats the vector of the fetch phase it extends (INST_FETCH or OP_FETCH).
  - HALTED: halt.
- stall=1: present state, wcnt, ret, all output registers and instr_count hold their values; run is ignored. Reset overrides stall.
- instr_count increments by 1 on each STORE->INST_ADDR transition and wraps from 2^CNT_W-1 to 0. HLT is not counted.

## Timing
- Reset (async assert, any state including WAIT): state=INST_ADDR, all seven strobes 0, instr_count=0, wcnt=0, ret=0.
- First edge after deassert: leaves INST_ADDR.
- Strobes are registered: the vector decoded in state S appears on the outputs one cycle after S is shown on `state`. The `state` port itself is unregistered.
- Instruction length is 8+2*MEM_WAIT cycles. With MEM_WAIT=0 the sequence is the plain 8-phase cycle.
- HLT to HALTED takes 4+MEM_WAIT cycles from INST_ADDR. halt is asserted the cycle after IDLE and stays asserted through HALTED.
- run=1 in HALTED: state=INST_ADDR on the next edge, and halt drops one cycle later.
- opcode and zero are sampled combinationally every cycle; upstream must hold them stable from INST_LOAD through ALU_OP.

## Test plan
- MEM_WAIT=0, opcode=ADD: state walks 0..7 in 8 cycles. mem_rd and load_ac are 1 on the output cycles following OP_FETCH and ALU_OP. instr_count goes 0->1.
- MEM_WAIT=3, opcode=LDA: 3 WAIT cycles after INST_FETCH and 3 after OP_FETCH, each holding the extended fetch vector. The cycle is 14 clocks and instr_count increments once.
- opcode=SKZ with zero=1 -> inc_pc high the cycle after OP_FETCH. With zero=0 -> inc_pc low there. opcode=JMP -> load_pc high after both OP_FETCH and ALU_OP. opcode=STO -> mem_wr high only after ALU_OP.
- opcode=HLT -> HALTED, halt held 1. Hold run=0 for 10 cycles: no change. Pulse run=1 -> INST_ADDR next edge, and halt=0 one cycle later.
- stall=1 for 5 cycles mid-WAIT (MEM_WAIT=4) -> state, strobes and wcnt frozen. On release the remaining wait count completes exactly.
- Assert rst_=0 mid-OP_FETCH -> outputs 0 and state 0 immediately, without waiting for a clock edge. CNT_W=2 after 4 instructions -> instr_count wraps to 0.
